// File: rtl/light_switch_ctrl.sv
// N-button light switch: per-button debounce, sticky requests, round-robin grant, toggle FSM.
// Optional auto-off timer is compiled in when LUZ_AUTO_OFF_EN is defined.
module light_switch_ctrl #(
  parameter int N_BTN   = 4,
  parameter int DEB_CYC = 4,
  parameter int TMO_CYC = 200,
  parameter int TMO_W   = 8
) (
  input  logic             sClk,
  input  logic             sReset,
  input  logic [N_BTN-1:0] sButtons,
  output logic             sLuz,
  output logic [N_BTN-1:0] sGrant,
  output logic [N_BTN-1:0] sPending,
  output logic             sTimeout
);

  localparam int CW = $clog2(DEB_CYC);
  localparam int PW = $clog2(N_BTN);

  typedef enum logic {OFF = 1'b0, ON = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [N_BTN-1:0]   grant_q, grant_d;
  logic [N_BTN-1:0]   pending_q, pending_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic               timeout_q, timeout_d;
  logic [N_BTN-1:0]   rise;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_deb
      logic          lvl_q, lvl_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          rise_d;

      always_comb begin
        lvl_d  = lvl_q;
        cnt_d  = cnt_q;
        rise_d = 1'b0;
        if (sButtons[gi] == lvl_q) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(DEB_CYC - 1)) begin
          lvl_d  = ~lvl_q;
          cnt_d  = '0;
          rise_d = ~lvl_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge sClk or negedge sReset) begin
        if (!sReset) begin
          lvl_q <= 1'b0;
          cnt_q <= '0;
        end else begin
          lvl_q <= lvl_d;
          cnt_q <= cnt_d;
        end
      end

      assign rise[gi] = rise_d;
    end
  endgenerate

  // Round-robin search starts at ptr_q and wraps; first pending bit wins.
  always_comb begin
    logic found;
    int   idx;
    grant_d = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = (int'(ptr_q) + k) % N_BTN;
      if (!found && pending_q[idx]) begin
        found        = 1'b1;
        grant_d[idx] = 1'b1;
        ptr_d        = PW'((idx + 1) % N_BTN);
      end
    end
  end

  // A new rise for a bit being granted on the same edge keeps the bit set.
  assign pending_d = (pending_q & ~grant_d) | rise;

`ifdef LUZ_AUTO_OFF_EN
  logic [TMO_W-1:0] timer_q, timer_d;

  always_comb begin
    state_d   = state_q;
    timer_d   = '0;
    timeout_d = 1'b0;
    if (|grant_d) begin
      state_d = (state_q == ON) ? OFF : ON;
    end else if (state_q == ON) begin
      if (timer_q == TMO_W'(TMO_CYC - 1)) begin
        state_d   = OFF;
        timeout_d = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sClk or negedge sReset) begin
    if (!sReset) timer_q <= '0;
    else         timer_q <= timer_d;
  end
`else
  logic [TMO_W-1:0] tmo_unused;
  assign tmo_unused = TMO_W'(TMO_CYC);

  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    if (|grant_d) state_d = (state_q == ON) ? OFF : ON;
  end
`endif

  always_ff @(posedge sClk or negedge sReset) begin
    if (!sReset) begin
      state_q   <= OFF;
      grant_q   <= '0;
      pending_q <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

  assign sLuz     = (state_q == ON);
  assign sGrant   = grant_q;
  assign sPending = pending_q;
  assign sTimeout = timeout_q;

endmodule
